// File: rtl/char_movement_controller.sv
// Per-frame player update: latches the requested move, waits for the collision verdict, then commits
// the step, attack window, damage and invincibility. Optional knockback is enabled by CHAR_KNOCKBACK_EN.
module char_movement_controller #(
  parameter logic [8:0] START_X       = 9'd120,
  parameter logic [7:0] START_Y       = 8'd80,
  parameter logic [8:0] MAX_X         = 9'd239,
  parameter logic [7:0] MAX_Y         = 8'd159,
  parameter logic [2:0] HP_MAX        = 3'd6,
  parameter logic [3:0] ATTACK_FRAMES = 4'd8,
`ifdef CHAR_KNOCKBACK_EN
  parameter logic [5:0] INVULN_FRAMES = 6'd48,
  parameter logic [3:0] KNOCKBACK_PX  = 4'd8
`else
  parameter logic [5:0] INVULN_FRAMES = 6'd48
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       init,
  input  logic [2:0] key_dir,
  input  logic       c_map_collision,
  input  logic       c_e_collision,
  input  logic       collision_done,
  output logic       collision_enable,
  output logic [8:0] char_x,
  output logic [7:0] char_y,
  output logic [2:0] direction_char,
  output logic [2:0] facing_char,
  output logic       attack,
  output logic [2:0] hp,
  output logic       invincible,
  output logic       dead,
  output logic       done
);

  localparam logic [2:0] DIR_NONE  = 3'b000;
  localparam logic [2:0] DIR_ATK   = 3'b001;
  localparam logic [2:0] DIR_UP    = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b011;
  localparam logic [2:0] DIR_LEFT  = 3'b100;
  localparam logic [2:0] DIR_RIGHT = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_WAIT_COL, S_UPDATE, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] dir_q, dir_d;
  logic [2:0] face_q, face_d;
  logic       atk_q, atk_d;
  logic [3:0] atk_cnt_q, atk_cnt_d;
  logic       atk_new_q, atk_new_d;
  logic [2:0] hp_q, hp_d;
  logic       inv_q, inv_d;
  logic [5:0] inv_cnt_q, inv_cnt_d;
  logic       dead_q, dead_d;
  logic       done_q, done_d;
  logic       cen_q, cen_d;
  logic       first_q, first_d;
  logic       map_q, map_d;
  logic       enemy_q, enemy_d;
`ifdef CHAR_KNOCKBACK_EN
  logic [3:0] kb_cnt_q, kb_cnt_d;
  logic [2:0] kb_dir_q, kb_dir_d;

  function automatic logic [2:0] opposite(input logic [2:0] d);
    unique case (d)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      default:   opposite = DIR_LEFT;
    endcase
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    face_d    = face_q;
    atk_d     = atk_q;
    atk_cnt_d = atk_cnt_q;
    atk_new_d = atk_new_q;
    hp_d      = hp_q;
    inv_d     = inv_q;
    inv_cnt_d = inv_cnt_q;
    dead_d    = dead_q;
    done_d    = 1'b0;
    cen_d     = cen_q;
    first_d   = first_q;
    map_d     = map_q;
    enemy_d   = enemy_q;
`ifdef CHAR_KNOCKBACK_EN
    kb_cnt_d  = kb_cnt_q;
    kb_dir_d  = kb_dir_q;
`endif
    // A fresh frame start anywhere outside IDLE abandons the current frame without committing it.
    if (init && state_q != S_IDLE) begin
      state_d = S_LATCH;
      cen_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (init) state_d = S_LATCH;
        S_LATCH: begin
          dir_d = DIR_NONE;
          if (!atk_q && !dead_q) begin
            if (key_dir >= DIR_UP && key_dir <= DIR_RIGHT) dir_d = key_dir;
            if (key_dir == DIR_ATK) begin
              atk_d     = 1'b1;
              atk_cnt_d = ATTACK_FRAMES;
              atk_new_d = 1'b1;
            end
          end
`ifdef CHAR_KNOCKBACK_EN
          if (kb_cnt_q != 4'd0 && !dead_q) dir_d = kb_dir_q;
`endif
          state_d = S_WAIT_COL;
          cen_d   = 1'b1;
          first_d = 1'b1;
        end
        S_WAIT_COL: begin
          // The detector is still clearing its previous done in the first cycle.
          first_d = 1'b0;
          if (!first_q && collision_done) begin
            map_d   = c_map_collision;
            enemy_d = c_e_collision;
            cen_d   = 1'b0;
            state_d = S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (dir_q != DIR_NONE) begin
            face_d = dir_q;
            if (!map_q) begin
              unique case (dir_q)
                DIR_UP:    y_d = (y_q == 8'd0) ? 8'd0 : y_q - 8'd1;
                DIR_DOWN:  y_d = (y_q >= MAX_Y) ? MAX_Y : y_q + 8'd1;
                DIR_LEFT:  x_d = (x_q == 9'd0) ? 9'd0 : x_q - 9'd1;
                default:   x_d = (x_q >= MAX_X) ? MAX_X : x_q + 9'd1;
              endcase
            end
          end
          if (atk_cnt_q != 4'd0 && !atk_new_q) begin
            atk_cnt_d = atk_cnt_q - 4'd1;
            if (atk_cnt_q == 4'd1) atk_d = 1'b0;
          end
          atk_new_d = 1'b0;
          if (inv_cnt_q != 6'd0) begin
            inv_cnt_d = inv_cnt_q - 6'd1;
            if (inv_cnt_q == 6'd1) inv_d = 1'b0;
          end
`ifdef CHAR_KNOCKBACK_EN
          if (kb_cnt_q != 4'd0) begin
            if (map_q) kb_cnt_d = 4'd0;
            else if (dir_q == kb_dir_q) kb_cnt_d = kb_cnt_q - 4'd1;
          end
`endif
          // Invincibility is judged on the value held going into this frame.
          if (enemy_q && !inv_q && !dead_q) begin
            hp_d      = hp_q - 3'd1;
            inv_d     = 1'b1;
            inv_cnt_d = INVULN_FRAMES;
            if (hp_q == 3'd1) dead_d = 1'b1;
`ifdef CHAR_KNOCKBACK_EN
            kb_cnt_d = KNOCKBACK_PX;
            kb_dir_d = opposite(face_d);
`endif
          end
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      x_q       <= START_X;
      y_q       <= START_Y;
      dir_q     <= DIR_NONE;
      face_q    <= DIR_UP;
      atk_q     <= 1'b0;
      atk_cnt_q <= 4'd0;
      atk_new_q <= 1'b0;
      hp_q      <= HP_MAX;
      inv_q     <= 1'b0;
      inv_cnt_q <= 6'd0;
      dead_q    <= 1'b0;
      done_q    <= 1'b0;
      cen_q     <= 1'b0;
      first_q   <= 1'b0;
      map_q     <= 1'b0;
      enemy_q   <= 1'b0;
`ifdef CHAR_KNOCKBACK_EN
      kb_cnt_q  <= 4'd0;
      kb_dir_q  <= DIR_NONE;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      face_q    <= face_d;
      atk_q     <= atk_d;
      atk_cnt_q <= atk_cnt_d;
      atk_new_q <= atk_new_d;
      hp_q      <= hp_d;
      inv_q     <= inv_d;
      inv_cnt_q <= inv_cnt_d;
      dead_q    <= dead_d;
      done_q    <= done_d;
      cen_q     <= cen_d;
      first_q   <= first_d;
      map_q     <= map_d;
      enemy_q   <= enemy_d;
`ifdef CHAR_KNOCKBACK_EN
      kb_cnt_q  <= kb_cnt_d;
      kb_dir_q  <= kb_dir_d;
`endif
    end
  end

  assign collision_enable = cen_q;
  assign char_x           = x_q;
  assign char_y           = y_q;
  assign direction_char   = dir_q;
  assign facing_char      = face_q;
  assign attack           = atk_q;
  assign hp               = hp_q;
  assign invincible       = inv_q;
  assign dead             = dead_q;
  assign done             = done_q;

endmodule
